// File: rtl/mips_pkg.sv
// Shared MIPS core types: move-from-HI/LO selector and the mul/div sequencer states.
package mips_pkg;
  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {MVHL_NONE = 2'b00, MVHL_LO = 2'b01, MVHL_HI = 2'b10} mvhl_t;
  typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_FIX} md_state_t;

  // Attributes of the in-flight operation, captured when it is launched
  typedef struct packed {
    logic mult;
    logic qneg;
    logic rneg;
    logic divz;
  } md_op_t;
endpackage

// File: rtl/muldiv_iter.sv
// Unsigned iterative datapath: one shift-add (MULT) or restoring shift-subtract (DIV) step per cycle.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               load,
  input  logic               step,
  input  logic               op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod_q,
  output logic [WIDTH-1:0]   rem_q
);
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   opnd;
  logic               op_q;
  logic [WIDTH:0]     add_s, trial;

  // MULT: acc = {partial, multiplier}; DIV: acc = {remainder, dividend/quotient}
  always_comb begin
    add_s   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    trial   = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    acc_nxt = acc;
    if (op_q)
      acc_nxt = {add_s, acc[WIDTH-1:1]};
    else if (!trial[WIDTH])
      acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (load) begin
      acc  <= {{WIDTH{1'b0}}, op ? b : a};
      opnd <= op ? a : b;
      op_q <= op;
    end else if (step) begin
      acc  <= acc_nxt;
    end
  end

  assign prod_q = acc;
  assign rem_q  = acc[2*WIDTH-1:WIDTH];
endmodule

// File: rtl/muldiv_unit.sv
// EX-stage MULT/DIV unit: sequencer, sign handling, HI/LO registers and MFHI/MFLO read port.
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             multordiv,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [1:0]       mvhl,
  output logic [WIDTH-1:0] hlread,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);
  localparam int CW = $clog2(WIDTH);

  md_state_t          state;
  md_op_t             op_q;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   srca_q, mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_q, prod_s;
  logic [WIDTH-1:0]   rem_q, quo_s, rem_s;
  logic               load, step;

  // Most-negative input maps to its own bit pattern, read back as an unsigned magnitude
  assign mag_a = srca[WIDTH-1] ? -srca : srca;
  assign mag_b = srcb[WIDTH-1] ? -srcb : srcb;
  assign load  = (state == MD_IDLE) && start;
  assign step  = (state == MD_CALC);

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .load   (load),
    .step   (step),
    .op     (multordiv),
    .a      (mag_a),
    .b      (mag_b),
    .prod_q (prod_q),
    .rem_q  (rem_q)
  );

  always_comb begin
    prod_s = op_q.qneg ? -prod_q : prod_q;
    quo_s  = op_q.qneg ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
    rem_s  = op_q.rneg ? -rem_q : rem_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= MD_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      count  <= '0;
      op_q   <= '0;
      srca_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        MD_IDLE: if (start) begin
          op_q.mult <= multordiv;
          op_q.qneg <= srca[WIDTH-1] ^ srcb[WIDTH-1];
          op_q.rneg <= srca[WIDTH-1];
          op_q.divz <= !multordiv && (srcb == '0);
          srca_q    <= srca;
          count     <= '0;
          busy      <= 1'b1;
          state     <= MD_CALC;
        end
        MD_CALC: begin
          count <= count + CW'(1);
          if (count == CW'(WIDTH-1)) state <= MD_FIX;
        end
        MD_FIX: begin
          if (op_q.mult) begin
            {hi, lo} <= prod_s;
          end else if (op_q.divz) begin
            hi <= srca_q;
            lo <= '1;
          end else begin
            hi <= rem_s;
            lo <= quo_s;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= MD_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= MD_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    hlread = '0;
    case (mvhl)
      MVHL_LO: hlread = lo;
      MVHL_HI: hlread = hi;
      default: hlread = '0;
    endcase
  end

  assign stall = busy && (start || mvhl == MVHL_LO || mvhl == MVHL_HI);
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: reset, vector table, random ops vs. arithmetic model, hazard corners.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, multordiv;
  logic [W-1:0] srca, srcb, hlread, hi, lo;
  logic [1:0]   mvhl;
  logic         busy, done, stall;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .multordiv(multordiv),
    .srca(srca), .srcb(srcb), .mvhl(mvhl), .hlread(hlread),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  typedef struct {
    logic         op;
    logic [W-1:0] a, b, eh, el;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Signed arithmetic reference: product, truncating divide, dividend-signed remainder
  task automatic model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] eh, output logic [W-1:0] el);
    longint sa, sb, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op) begin
      r = sa * sb; u = r;
      eh = u[63:32]; el = u[31:0];
    end else if (b == 0) begin
      eh = a; el = '1;
    end else begin
      r = sa / sb; u = r; el = u[31:0];
      r = sa % sb; u = r; eh = u[31:0];
    end
  endtask

  // Called at a negedge; launches at the next posedge and checks the full latency window
  task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input string tag);
    int bad;
    start = 1'b1; multordiv = op; srca = a; srcb = b;
    @(posedge clk);
    bad = 0;
    for (int c = 1; c <= W + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0; srca = $urandom; srcb = $urandom; multordiv = $urandom_range(0, 1);
      end
      if (!busy || done) bad++;
    end
    chk({tag, "_busywin"}, 64'(bad), 64'd0);
    @(negedge clk);
    chk({tag, "_done"}, {62'd0, done, busy}, 64'b10);
    chk({tag, "_hilo"}, {hi, lo}, {eh, el});
  endtask

  vec_t vecs[$];
  logic [W-1:0] eh, el, ra, rb;
  logic rop;
  int bad;

  initial begin
    reset = 1'b1; start = 1'b0; multordiv = 1'b0; srca = '0; srcb = '0; mvhl = 2'b00;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", {hi, lo}, 64'd0);
    chk("rst_flags", {61'd0, busy, done, stall}, 64'd0);
    for (int m = 0; m < 4; m++) begin
      mvhl = 2'(m); #1;
      chk($sformatf("rst_hlread%0d", m), 64'(hlread), 64'd0);
    end
    mvhl = 2'b00;
    reset = 1'b0;
    @(negedge clk);

    // Directed table; consecutive runs also launch in the done cycle of the previous op
    vecs.push_back('{1'b1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB});
    vecs.push_back('{1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});
    vecs.push_back('{1'b0, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF});
    vecs.push_back('{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});
    vecs.push_back('{1'b1, 32'd6,        32'd7,        32'h00000000, 32'h0000002A});
    vecs.push_back('{1'b0, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD});
    vecs.push_back('{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
    vecs.push_back('{1'b0, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF});
    vecs.push_back('{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001});
    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el, $sformatf("vec%0d", i));

    // Random operations against the arithmetic model
    for (int i = 0; i < 24; i++) begin
      rop = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: begin ra = 32'h80000000; rb = '1; end
        2: rb = 32'($urandom_range(1, 17));
        default: ;
      endcase
      model(rop, ra, rb, eh, el);
      run_op(rop, ra, rb, eh, el, $sformatf("rnd%0d", i));
    end

    // MFLO after MULT 7 x -3
    run_op(1'b1, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, "m7x-3");
    mvhl = 2'b01; #1;
    chk("mflo_after", 64'(hlread), 64'hFFFFFFEB);

    // MFHI held across MULT 6 x 7 launched together with it from IDLE
    mvhl = 2'b10; start = 1'b1; multordiv = 1'b1; srca = 32'd6; srcb = 32'd7; #1;
    chk("idle_start_mfhi", {31'd0, stall, hlread}, {31'd0, 1'b0, 32'hFFFFFFFF});
    @(posedge clk);
    bad = 0;
    for (int c = 1; c <= W + 1; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      #1;
      if (!stall || hlread !== 32'hFFFFFFFF) bad++;
    end
    chk("mfhi_stall_win", 64'(bad), 64'd0);
    @(negedge clk); #1;
    chk("mfhi_done", {30'd0, done, stall, hlread}, {30'd0, 1'b1, 1'b0, 32'd0});
    mvhl = 2'b01; #1;
    chk("mflo_42", 64'(hlread), 64'd42);
    mvhl = 2'b11; #1;
    chk("mvhl_rsvd", 64'(hlread), 64'd0);
    mvhl = 2'b00;
    @(negedge clk);

    // Second start while busy is stalled and ignored
    start = 1'b1; multordiv = 1'b1; srca = 32'h1234; srcb = 32'h10;
    @(posedge clk);
    bad = 0;
    for (int c = 1; c <= W + 1; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 5) begin
        start = 1'b1; multordiv = 1'b0; srca = 32'd100; srcb = 32'd3; #1;
        chk("busy_start_stall", 64'(stall), 64'd1);
      end
      if (c == 6) start = 1'b0;
      if (!busy || done) bad++;
    end
    chk("busy_start_win", 64'(bad), 64'd0);
    @(negedge clk);
    chk("busy_start_res", {31'd0, done, hi, lo}, {31'd0, 1'b1, 32'd0, 32'h12340});

    // Reset during a DIV aborts it and clears HI/LO
    start = 1'b1; multordiv = 1'b0; srca = 32'd1000; srcb = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_state", {30'd0, busy, done, hi}, 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy || hi != 0 || lo != 0) bad++;
    end
    chk("abort_quiet", 64'(bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
